// File: rtl/dma_copy_engine_if.sv
// DMA bus bundle between the copy engine (master) and memory/core (slave).
//   dma_addr  : byte address, bit 0 always 0       (master -> slave)
//   dma_en    : request                            (master -> slave)
//   dma_we    : byte write enables, 11 write/00 rd (master -> slave)
//   dma_din   : write data                         (master -> slave)
//   dma_dout  : read data, valid the cycle after accept (slave -> master)
//   dma_ready : accept when dma_en && dma_ready    (slave -> master)
//   dma_resp  : bus error, sampled in accept cycle (slave -> master)
interface dma_copy_engine_if;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic [15:0] dma_din;
  logic [15:0] dma_dout;
  logic        dma_ready;
  logic        dma_resp;

  modport master (
    output dma_addr, dma_en, dma_we, dma_din,
    input  dma_dout, dma_ready, dma_resp
  );

  modport slave (
    input  dma_addr, dma_en, dma_we, dma_din,
    output dma_dout, dma_ready, dma_resp
  );
endinterface

// File: rtl/dma_copy_engine.sv
// Word-granular DMA copy engine. Copies len 16-bit words from src_addr to
// dst_addr, one read then one write per word, refusing any command whose
// source or destination span is misaligned, wraps past 16'hFFFF, or touches
// the secure window [SMEM_BASE, SMEM_BASE+SMEM_SIZE-1].
//   clk, reset          : clock, asynchronous active-high reset
//   start               : command strobe, sampled only in IDLE
//   src_addr/dst_addr   : even byte addresses
//   len                 : word count, 0..255
//   abort               : level, terminates an active command
//   dma                 : bus master port (see dma_copy_engine_if)
//   busy                : high in RD, CAP, WR
//   done                : one-cycle pulse ending every accepted command
//   err, err_code       : result of the last command (01 param, 10 secure,
//                         11 bus error/abort), held until the next start
module dma_copy_engine #(
  parameter logic [15:0] SMEM_BASE = 16'hE000,
  parameter logic [15:0] SMEM_SIZE = 16'h1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       src_addr,
  input  logic [15:0]       dst_addr,
  input  logic [7:0]        len,
  input  logic              abort,
  dma_copy_engine_if.master dma,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [1:0] E_NONE   = 2'b00;
  localparam logic [1:0] E_PARAM  = 2'b01;
  localparam logic [1:0] E_SECURE = 2'b10;
  localparam logic [1:0] E_BUS    = 2'b11;

  localparam logic [16:0] WIN_LO = {1'b0, SMEM_BASE};
  localparam logic [16:0] WIN_HI = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE} - 17'd1;

  logic [2:0]  state_q, state_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, buf_q, buf_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]  we_q, we_d;
  logic [15:0] addr_q, addr_d, din_q, din_d;

  // Span checks in 17 bits so a span running past 16'hFFFF shows up in bit 16.
  // A zero-length command has no span, so only alignment is checked for it.
  logic [16:0] span_bytes, src_end, dst_end;
  logic        bad_param, sec_hit, accept;

  assign span_bytes = {8'd0, len, 1'b0};
  assign src_end    = {1'b0, src_addr} + span_bytes - 17'd1;
  assign dst_end    = {1'b0, dst_addr} + span_bytes - 17'd1;
  assign bad_param  = src_addr[0] | dst_addr[0] |
                      ((len != 8'd0) & (src_end[16] | dst_end[16]));
  assign sec_hit    = (len != 8'd0) &
                      ((({1'b0, src_addr} <= WIN_HI) & (src_end >= WIN_LO)) |
                       (({1'b0, dst_addr} <= WIN_HI) & (dst_end >= WIN_LO)));
  assign accept     = en_q & dma.dma_ready;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = err_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          cnt_d  = len;
          err_d  = 1'b0;
          code_d = E_NONE;
          if (bad_param) begin
            state_d = S_FIN; err_d = 1'b1; code_d = E_PARAM;
          end else if (sec_hit) begin
            state_d = S_FIN; err_d = 1'b1; code_d = E_SECURE;
          end else if (len == 8'd0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (abort || (accept && dma.dma_resp)) begin
          state_d = S_FIN; err_d = 1'b1; code_d = E_BUS;
        end else if (accept) begin
          state_d = S_CAP;
        end
      end
      S_CAP: begin
        if (abort) begin
          state_d = S_FIN; err_d = 1'b1; code_d = E_BUS;
        end else begin
          buf_d   = dma.dma_dout;
          state_d = S_WR;
        end
      end
      S_WR: begin
        // An accepted write is issued even if abort wins the state decision.
        if (accept) begin
          src_d = src_q + 16'd2;
          dst_d = dst_q + 16'd2;
          cnt_d = cnt_q - 8'd1;
        end
        if (abort || (accept && dma.dma_resp)) begin
          state_d = S_FIN; err_d = 1'b1; code_d = E_BUS;
        end else if (accept) begin
          state_d = (cnt_d != 8'd0) ? S_RD : S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops together.
    en_d   = (state_d == S_RD) || (state_d == S_WR);
    we_d   = (state_d == S_WR) ? 2'b11 : 2'b00;
    addr_d = (state_d == S_RD) ? src_d : ((state_d == S_WR) ? dst_d : '0);
    din_d  = (state_d == S_WR) ? buf_d : '0;
    busy_d = (state_d == S_RD) || (state_d == S_CAP) || (state_d == S_WR);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= E_NONE;
      en_q    <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      code_q  <= code_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dma.dma_en   = en_q;
  assign dma.dma_we   = we_q;
  assign dma.dma_addr = addr_q;
  assign dma.dma_din  = din_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = code_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: a word-array memory answers the bus with
// random wait states; each command is predicted by a sequential word-copy
// model over a snapshot of memory, and the bus transaction list, result
// code, done timing and final memory are compared against it.
module tb_dma_copy_engine;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } xact_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_addr, dst_addr;
  logic [7:0]  len;
  logic        abort;
  logic        busy, done, err;
  logic [1:0]  err_code;

  dma_copy_engine_if bus_if ();

  dma_copy_engine #(.SMEM_BASE(16'hE000), .SMEM_SIZE(16'h1000)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .abort    (abort),
    .dma      (bus_if),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] mem [0:32767];
  logic [15:0] mm  [0:32767];
  xact_t act_q[$];
  int wait_pct   = 0;
  int force_wait = 0;
  int resp_at    = -1;
  int xact_n     = 0;
  int nwaits     = 0;
  int sec_viol   = 0;
  int ndone      = 0;

  // Memory responder: decides ready/resp each cycle, logs accepted transfers.
  initial begin : responder
    logic [15:0] a;
    bus_if.dma_ready = 1'b0;
    bus_if.dma_resp  = 1'b0;
    bus_if.dma_dout  = '0;
    forever begin
      @(negedge clk);
      bus_if.dma_resp = 1'b0;
      if (bus_if.dma_en) begin
        a = bus_if.dma_addr;
        if (force_wait > 0) begin
          bus_if.dma_ready = 1'b0;
          force_wait--;
        end else begin
          bus_if.dma_ready = ($urandom_range(99) >= wait_pct);
        end
        if (!bus_if.dma_ready) nwaits++;
        else begin
          bus_if.dma_resp = (xact_n == resp_at);
          if (bus_if.dma_we == 2'b11) begin
            act_q.push_back('{1'b1, a, bus_if.dma_din});
            if (!bus_if.dma_resp) mem[a[15:1]] = bus_if.dma_din;
          end else begin
            act_q.push_back('{1'b0, a, mem[a[15:1]]});
            bus_if.dma_dout = bus_if.dma_resp ? 16'hBAD0 : mem[a[15:1]];
          end
          xact_n++;
        end
      end else begin
        bus_if.dma_ready = 1'($urandom_range(1));
      end
    end
  end

  initial begin : secure_monitor
    forever begin
      @(negedge clk);
      if (bus_if.dma_en && bus_if.dma_addr >= 16'hE000 && bus_if.dma_addr <= 16'hEFFF)
        sec_viol++;
    end
  end

  function automatic logic [15:0] pick_addr();
    logic [15:0] a;
    case ($urandom_range(5))
      0, 1, 2: a = {3'b000, 12'($urandom), 1'b0};
      3:       a = {3'b001, 12'($urandom), 1'b1};
      4:       a = (($urandom_range(1) == 1) ? 16'hE000 : 16'hF000) - 16'(2 * $urandom_range(10));
      default: a = 16'hFFFE - 16'(2 * $urandom_range(10));
    endcase
    return a;
  endfunction

  task automatic run_cmd(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n,
                         input int rsp_at, input int abort_word, input bit poke,
                         input bit chk_time, input int stable_n);
    int code, se, de, t0, tdone, aborted, diffs, nexp, ni;
    bit rej;
    logic [15:0] ra, wa, v, abort_addr;
    xact_t exp_q[$];

    // Reference: result code from the command rules, then a word-by-word copy.
    ni   = int'(n);
    se   = int'(s) + 2 * ni - 1;
    de   = int'(d) + 2 * ni - 1;
    code = 0;
    if (s[0] || d[0]) code = 1;
    else if (ni != 0) begin
      if (se > 'hFFFF || de > 'hFFFF) code = 1;
      else if ((int'(s) <= 'hEFFF && se >= 'hE000) || (int'(d) <= 'hEFFF && de >= 'hE000)) code = 2;
    end
    rej = (code != 0);
    mm = mem;
    if (code == 0) begin
      for (int i = 0; i < ni; i++) begin
        ra = s + 16'(2 * i);
        wa = d + 16'(2 * i);
        v  = mm[ra[15:1]];
        exp_q.push_back('{1'b0, ra, v});
        if (rsp_at == 2 * i) begin code = 3; break; end
        exp_q.push_back('{1'b1, wa, v});
        if (rsp_at == 2 * i + 1) begin code = 3; break; end
        mm[wa[15:1]] = v;
        if (abort_word == i) begin code = 3; break; end
      end
    end
    abort_addr = d + 16'(2 * abort_word);

    act_q.delete();
    xact_n  = 0;
    nwaits  = 0;
    resp_at = rsp_at;
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    t0 = cyc; tdone = -1; aborted = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (k == 1) begin
        check("busy_T1", 64'(busy), 64'(!rej && ni != 0));
        check("err_T1", 64'(err), 64'(rej));
      end
      if (k <= stable_n)
        check("wait_stable", 64'({bus_if.dma_en, bus_if.dma_we, bus_if.dma_addr}), 64'({1'b1, 2'b00, s}));
      if (aborted == 1) begin
        check("abort_en_low", 64'(bus_if.dma_en), 64'd0);
        aborted = 2;
      end
      if (done) begin tdone = cyc; break; end
      if (abort_word >= 0 && aborted == 0 && bus_if.dma_en && bus_if.dma_we == 2'b11 &&
          bus_if.dma_addr == abort_addr) begin
        abort = 1'b1;
        aborted = 1;
      end
      if (poke) begin
        start    = 1'($urandom_range(1));
        src_addr = 16'($urandom);
        dst_addr = 16'($urandom);
        len      = 8'($urandom);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    check("done_seen", 64'(tdone >= 0), 64'd1);
    check("err", 64'(err), 64'(code != 0));
    check("err_code", 64'(err_code), 64'(code));
    if (chk_time && tdone >= 0)
      check("done_time", 64'(tdone - t0), 64'((rej || ni == 0) ? 1 : 3 * ni + nwaits + 1));
    @(negedge clk);
    check("done_pulse", 64'({done, busy}), 64'd0);
    nexp = exp_q.size();
    check("xact_count", 64'(act_q.size()), 64'(nexp));
    for (int i = 0; i < nexp && i < act_q.size(); i++)
      check("xact", 64'({act_q[i].we, act_q[i].addr, act_q[i].data}),
                    64'({exp_q[i].we, exp_q[i].addr, exp_q[i].data}));
    diffs = 0;
    for (int i = 0; i < 32768; i++) if (mem[i] !== mm[i]) diffs++;
    check("mem_diffs", 64'(diffs), 64'd0);
    resp_at = -1;
  endtask

  initial begin : main
    logic [15:0] s, d;
    logic [7:0]  n;
    int rsp;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    repeat (2) @(negedge clk);
    check("reset_state", 64'({bus_if.dma_en, bus_if.dma_we, bus_if.dma_addr, bus_if.dma_din,
                              busy, done, err, err_code}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic copy, zero wait: done at T+10.
    wait_pct = 0;
    run_cmd(16'h0200, 16'h0400, 8'd3, -1, -1, 1'b0, 1'b1, 0);
    // Secure overlap and bad parameters.
    run_cmd(16'hDFFE, 16'h0100, 8'd2, -1, -1, 1'b0, 1'b1, 0);
    run_cmd(16'h0201, 16'h0400, 8'd2, -1, -1, 1'b0, 1'b1, 0);
    run_cmd(16'h0300, 16'hFFFE, 8'd2, -1, -1, 1'b0, 1'b1, 0);
    // Four wait cycles on the first read, bus error on the second write.
    force_wait = 4;
    run_cmd(16'h1000, 16'h1800, 8'd3, 3, -1, 1'b0, 1'b0, 5);
    // Abort during the write of word 2 of 5.
    run_cmd(16'h2000, 16'h2800, 8'd5, -1, 1, 1'b0, 1'b0, 0);

    // Reset pulsed mid-RD.
    force_wait = 3;
    @(negedge clk);
    start = 1'b1; src_addr = 16'h0600; dst_addr = 16'h0800; len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    check("rst_pre_en", 64'(bus_if.dma_en), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async", 64'({bus_if.dma_en, bus_if.dma_we, bus_if.dma_addr, bus_if.dma_din,
                            busy, done, err, err_code}), 64'd0);
    ndone = 0;
    @(negedge clk);
    if (done) ndone++;
    reset = 1'b0;
    force_wait = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_no_done", 64'(ndone), 64'd0);
    // Failing command, then len=0 clears err with done at T+1.
    run_cmd(16'h0201, 16'h0400, 8'd1, -1, -1, 1'b0, 1'b1, 0);
    run_cmd(16'h0100, 16'h0300, 8'd0, -1, -1, 1'b0, 1'b1, 0);
    // Start strobes while busy are ignored.
    wait_pct = 20;
    run_cmd(16'h3000, 16'h3400, 8'd6, -1, -1, 1'b1, 1'b1, 0);

    for (int r = 0; r < 40; r++) begin
      s = pick_addr();
      d = pick_addr();
      n = ($urandom_range(8) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      wait_pct = int'($urandom_range(40));
      rsp = ($urandom_range(4) == 0) ? int'($urandom_range(2 * int'(n))) : -1;
      run_cmd(s, d, n, rsp, -1, ($urandom_range(3) == 0), (rsp < 0), 0);
    end

    check("secure_invariant", 64'(sec_viol), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
# dma_copy_engine

Word-granular DMA initiator that copies a block of 16-bit words from a source to a destination region over the openMSP430-style DMA port. It is the master side of the bus that the secure-region DMA monitor watches. The engine polices itself: it refuses any transfer whose source or destination touches the secure memory window, and it aborts cleanly when the monitor or software asserts `abort`. It sits between a software-programmed command register block and the core's DMA interface.

## Interface
- `SMEM_BASE`, 16'hE000, first byte address of the protected window.
- `SMEM_SIZE`, 16'h1000, window size in bytes; the window is [SMEM_BASE, SMEM_BASE+SMEM_SIZE-1].
- `clk` input 1: single clock; all state is on the rising edge.
- `reset` input 1: asynchronous, active-high; forces IDLE and all outputs low.
- `start` input 1: command strobe, sampled only in IDLE.
- `src_addr` input 16: source byte address; must be even.
- `dst_addr` input 16: destination byte address; must be even.
- `len` input 8: number of words, 0–255.
- `abort` input 1: level; terminates any active command.
- `dma_addr` output 16: bus byte address; bit 0 is always 0.
- `dma_en` output 1: bus request.
- `dma_we` output 2: byte write enables; 2'b11 on writes, 2'b00 on reads.
- `dma_din` output 16: write data to memory.
- `dma_dout` input 16: read data from memory.
- `dma_ready` input 1: the request is accepted in any cycle where `dma_en && dma_ready`.
- `dma_resp` input 1: bus error, sampled in the accept cycle.
- `busy` output 1: high in RD, CAP, WR.
- `done` output 1: one-cycle pulse ending every accepted command.
- `err` output 1: the last command failed; holds until the next accepted `start`.
- `err_code` output 2: 00 none, 01 misaligned or address wrap, 10 secure-window overlap, 11 bus error or abort.

## Operation
- States: IDLE, RD, CAP, WR, FIN.
- **Command acceptance (IDLE, `start`=1):** latch `src`, `dst`, and `len` into `cnt`; clear `err`/`err_code`. Range checks use 17-bit arithmetic, with the span end = addr + 2·len − 1.
  - `src` or `dst` odd, or either span end > 16'hFFFF: go to FIN with err=1, code 01.
  - Either span overlaps the secure window: go to FIN with err=1, code 10. Code 01 takes priority over code 10.
  - `len`=0: go to FIN with no error and no bus cycle.
  - Otherwise: go to RD.
- **RD:** `dma_en`=1, `dma_we`=00, `dma_addr`=src. Hold until accept. On accept, go to CAP, or to FIN with code 11 if `dma_resp`=1.
- **CAP:** `dma_en`=0; capture `dma_dout` into the data buffer; go to WR.
- **WR:** `dma_en`=1, `dma_we`=11, `dma_addr`=dst, `dma_din`=buffer. Hold until accept. On accept: src+=2, dst+=2, cnt−=1. Then go to RD if cnt≠0, else FIN. If `dma_resp`=1, go to FIN with code 11 instead.
- **FIN:** `done`=1 for one cycle, then IDLE.
- **Abort:** `abort`=1 in RD, CAP, or WR goes to FIN next cycle with err=1, code 11, and `dma_en` low from that cycle on. Abort takes priority over an accept in the same cycle: the accepted write is counted as issued, but the command still errors. `abort` is ignored in IDLE and FIN.
- `start` while busy is ignored.
- Address/data outputs are don't-care while `dma_en`=0, but are driven to 0 in IDLE.

## Timing
- Reset values: `dma_en`=0, `dma_we`=00, `dma_addr`=0, `dma_din`=0, `busy`=0, `done`=0, `err`=0, `err_code`=00. The state is IDLE.
- Reset asserted mid-transfer drops `dma_en` immediately (asynchronously). No `done` pulse is produced.
- With `start` at cycle T:
  - A rejected command or `len`=0 gives `done` at T+1.
  - Otherwise RD is at T+1.
- With zero-wait `dma_ready`, each word takes 3 cycles (RD, CAP, WR), and `done` is at T+3N+1. Each wait cycle adds one cycle.
- Outputs are registered (Moore), except the asynchronous reset clear.
- `dma_en` never rises for an address inside the secure window. This is an invariant to assert in verification.
- After FIN, the next `start` is accepted in the first IDLE cycle.

## Test plan
- **Basic copy:** src=0x0200, dst=0x0400, len=3, `dma_ready`=1 -> reads 0x0200/02/04 and writes 0x0400/02/04 carry the read data; `done` at T+10; err=0.
- **Secure overlap:** src=0xDFFE, len=2 (span touches 0xE000) -> no `dma_en`; `done` at T+1; err=1, code 10.
- **Bad parameters:** src=0x0201 -> code 01. Separately, dst=0xFFFE, len=2 -> code 01. Neither issues a bus cycle.
- **Wait states and bus error:** `dma_ready` low 4 cycles on the first read -> `dma_en`/`dma_addr` stable throughout. A later write with `dma_resp`=1 -> FIN, code 11, no further cycles.
- **Abort and reset:** `abort` asserted during WR of word 2 of 5 -> `dma_en` low next cycle, `done`+code 11. Separately, `reset` pulsed mid-RD -> all outputs 0 at once and no `done`. A subsequent `start` with len=0 -> `done` at T+1 and err cleared.
- **Start while busy** -> ignored; the original command completes unchanged.
